// File: rtl/gry_bin_conv_ser.sv
// Bit-serial Gray<->binary converter, MSB first, one bit per clock, valid/ready on both sides.
// Optional single-entry result cache short-circuits a repeat of the last accepted word.
module gry_bin_conv_ser #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          SKIP_SAME = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int unsigned IDXW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             m_q, m_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             prev_q, prev_d;
    logic             hit_q, hit_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             cache_vld_q, cache_vld_d;
    logic [WIDTH-1:0] cache_d_q, cache_d_d;
    logic             cache_m_q, cache_m_d;
    logic [WIDTH-1:0] cache_r_q, cache_r_d;

    logic             bit_c;
    logic [WIDTH-1:0] r_nxt_c;

    assign in_ready  = (state_q == IDLE) & ~rst;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // prev_q carries r[i+1] for Gray->binary and d[i+1] for binary->Gray
    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        m_d         = m_q;
        r_d         = r_q;
        idx_d       = idx_q;
        prev_d      = prev_q;
        hit_d       = hit_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        cache_vld_d = cache_vld_q;
        cache_d_d   = cache_d_q;
        cache_m_d   = cache_m_q;
        cache_r_d   = cache_r_q;

        bit_c          = prev_q ^ d_q[idx_q];
        r_nxt_c        = r_q;
        r_nxt_c[idx_q] = bit_c;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    d_d     = in_data;
                    m_d     = in_mode;
                    idx_d   = IDXW'(WIDTH - 1);
                    r_d     = '0;
                    prev_d  = 1'b0;
                    hit_d   = SKIP_SAME && cache_vld_q &&
                              (in_data == cache_d_q) && (in_mode == cache_m_q);
                    state_d = CALC;
                end
            end
            CALC: begin
                if (hit_q) begin
                    out_data_d  = cache_r_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    r_d    = r_nxt_c;
                    prev_d = m_q ? d_q[idx_q] : bit_c;
                    if (idx_q == '0) begin
                        out_data_d  = r_nxt_c;
                        out_valid_d = 1'b1;
                        cache_vld_d = 1'b1;
                        cache_d_d   = d_q;
                        cache_m_d   = m_q;
                        cache_r_d   = r_nxt_c;
                        state_d     = DONE;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            d_q         <= '0;
            m_q         <= 1'b0;
            r_q         <= '0;
            idx_q       <= '0;
            prev_q      <= 1'b0;
            hit_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            cache_vld_q <= 1'b0;
            cache_d_q   <= '0;
            cache_m_q   <= 1'b0;
            cache_r_q   <= '0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            m_q         <= m_d;
            r_q         <= r_d;
            idx_q       <= idx_d;
            prev_q      <= prev_d;
            hit_q       <= hit_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            cache_vld_q <= cache_vld_d;
            cache_d_q   <= cache_d_d;
            cache_m_q   <= cache_m_d;
            cache_r_q   <= cache_r_d;
        end
    end

endmodule

// File: tb/tb_gry_bin_conv_ser.sv
// Bench for gry_bin_conv_ser: directed WIDTH=4 scenarios plus 1000 random WIDTH=8 words
// scored against an arithmetic Gray/binary reference and a queue.
module tb_gry_bin_conv_ser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       iv4, ir4, im4, ov4, or4, busy4;
    logic [3:0] id4, od4;
    logic       iv8, ir8, im8, ov8, or8, busy8;
    logic [7:0] id8, od8;

    int checks = 0;
    int errors = 0;

    // bench-side model of the single-entry cache, used to predict latency
    logic       c_valid;
    logic [3:0] c_d;
    logic       c_m;

    gry_bin_conv_ser #(.WIDTH(4), .SKIP_SAME(1'b1)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(iv4), .in_ready(ir4), .in_data(id4), .in_mode(im4),
        .out_valid(ov4), .out_ready(or4), .out_data(od4), .busy(busy4)
    );

    gry_bin_conv_ser #(.WIDTH(8), .SKIP_SAME(1'b1)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_mode(im8),
        .out_valid(ov8), .out_ready(or8), .out_data(od8), .busy(busy8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gray_to_bin(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [7:0] ref_conv(input logic [7:0] d, input logic m);
        return m ? (d ^ (d >> 1)) : gray_to_bin(d);
    endfunction

    task automatic send4(input string tag, input logic [3:0] d, input logic m,
                         output logic [3:0] e);
        int n;
        int exp_lat;
        e       = 4'(ref_conv(8'(d), m));
        exp_lat = (c_valid && d == c_d && m == c_m) ? 1 : 4;
        @(negedge clk);
        iv4 = 1'b1; id4 = d; im4 = m;
        #1 check({tag, "/in_ready"}, 32'(ir4), 32'd1);
        @(posedge clk);
        #1;
        iv4 = 1'b0; id4 = 4'($urandom); im4 = 1'($urandom);
        n = 0;
        while (!ov4 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "/latency"}, 32'(n), 32'(exp_lat));
        check({tag, "/data"}, 32'(od4), 32'(e));
        check({tag, "/in_ready_done"}, 32'(ir4), 32'd0);
        c_valid = 1'b1; c_d = d; c_m = m;
    endtask

    task automatic release4(input string tag, input logic [3:0] e);
        @(negedge clk);
        or4 = 1'b1;
        @(posedge clk);
        #1;
        or4 = 1'b0;
        check({tag, "/valid_drop"}, 32'(ov4), 32'd0);
        check({tag, "/in_ready_after"}, 32'(ir4), 32'd1);
        check({tag, "/data_kept"}, 32'(od4), 32'(e));
    endtask

    initial begin
        logic [3:0] e;
        logic [3:0] held;
        logic [7:0] q[$];
        logic [7:0] last_d;
        logic [7:0] exp8;
        logic       last_m;
        int acc, got, cyc;

        rst = 1'b1;
        iv4 = 1'b0; id4 = '0; im4 = 1'b0; or4 = 1'b0;
        iv8 = 1'b0; id8 = '0; im8 = 1'b0; or8 = 1'b0;
        c_valid = 1'b0; c_d = '0; c_m = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst/in_ready", 32'(ir4), 32'd0);
        check("rst/out_valid", 32'(ov4), 32'd0);
        check("rst/out_data", 32'(od4), 32'd0);
        check("rst/busy", 32'(busy4), 32'd0);
        check("rst/in_ready8", 32'(ir8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst/in_ready_rel", 32'(ir4), 32'd1);

        // basic conversions, cache hit and cache miss on a mode change
        send4("t1", 4'b1101, 1'b0, e);  check("t1/ref", 32'(e), 32'b1001); release4("t1", e);
        send4("t3hit", 4'b1101, 1'b0, e); release4("t3hit", e);
        send4("t3m1", 4'b1101, 1'b1, e); check("t3m1/ref", 32'(e), 32'b1011); release4("t3m1", e);
        send4("t2a", 4'b1001, 1'b1, e); release4("t2a", e);
        send4("t2b", 4'b1000, 1'b0, e); release4("t2b", e);
        send4("t2c", 4'b0110, 1'b1, e); release4("t2c", e);

        // back-pressure holds the result and blocks new input
        send4("t4", 4'b0101, 1'b0, held);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            iv4 = k[0]; id4 = 4'($urandom); im4 = 1'($urandom);
            #1;
            check("t4/hold_valid", 32'(ov4), 32'd1);
            check("t4/hold_data", 32'(od4), 32'(held));
            check("t4/hold_ready", 32'(ir4), 32'd0);
        end
        @(negedge clk);
        iv4 = 1'b0;
        release4("t4", held);
        @(posedge clk);
        #1;
        check("t4/no_ghost_valid", 32'(ov4), 32'd0);
        check("t4/no_ghost_busy", 32'(busy4), 32'd0);

        // reset during the second CALC cycle aborts the word and clears the cache
        send4("t5pre", 4'b0110, 1'b1, e); release4("t5pre", e);
        @(negedge clk);
        iv4 = 1'b1; id4 = 4'b0011; im4 = 1'b0;
        @(posedge clk);
        #1;
        iv4 = 1'b0;
        check("t5/busy_calc", 32'(busy4), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5/rst_valid", 32'(ov4), 32'd0);
        check("t5/rst_data", 32'(od4), 32'd0);
        check("t5/rst_busy", 32'(busy4), 32'd0);
        check("t5/rst_ready", 32'(ir4), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        c_valid = 1'b0;
        #1 check("t5/ready_rel", 32'(ir4), 32'd1);
        send4("t5miss", 4'b0110, 1'b1, e); release4("t5miss", e);
        send4("t5zero", 4'b0000, 1'b0, e); check("t5zero/ref", 32'(e), 32'd0); release4("t5zero", e);

        // random words on the 8-bit instance, scoreboarded in order
        acc = 0; got = 0; cyc = 0;
        last_d = '0; last_m = 1'b0;
        while ((acc < 1000 || q.size() > 0) && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (acc < 1000) begin
                iv8 = ($urandom_range(0, 9) < 6);
                if ($urandom_range(0, 3) == 0) begin
                    id8 = last_d; im8 = last_m;
                end else begin
                    id8 = 8'($urandom); im8 = 1'($urandom);
                end
            end else begin
                iv8 = 1'b0;
            end
            or8 = ($urandom_range(0, 9) < 6);
            #1;
            if (iv8 && ir8) begin
                q.push_back(ref_conv(id8, im8));
                acc++;
                last_d = id8; last_m = im8;
            end
            if (ov8 && or8) begin
                check("rand/spurious_valid", 32'(q.size() == 0), 32'd0);
                if (q.size() > 0) begin
                    exp8 = q.pop_front();
                    check("rand/data", 32'(od8), 32'(exp8));
                    got++;
                end
            end
        end
        iv8 = 1'b0; or8 = 1'b0;
        check("rand/accepted", 32'(acc), 32'd1000);
        check("rand/delivered", 32'(got), 32'd1000);
        check("rand/pending", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
